// File: rtl/sprite_sched_pkg.sv
// Shared types, geometry constants and address helper for the sprite fetch scheduler.
package sprite_sched_pkg;

  localparam int unsigned NUM_SPRITES = 4;
  localparam int unsigned SPR_W       = 43;
  localparam int unsigned SPR_H       = 50;
  localparam int unsigned SPR_SIZE    = SPR_W * SPR_H;
  localparam int unsigned ADDR_W      = 14;
  localparam int unsigned IDX_W       = 9;
  localparam int unsigned ID_W        = $clog2(NUM_SPRITES);
  // Width of a local pixel offset inside one sprite (max(SPR_W, SPR_H) - 1 fits).
  localparam int unsigned OFF_W       = 6;

  localparam logic [IDX_W-1:0] TRANSP_IDX = '0;

  typedef struct packed {
    logic       en;
    logic [9:0] x;
    logic [9:0] y;
  } slot_t;

  typedef enum logic [0:0] {StRun, StCommit} state_e;

  // First ROM word of a slot's image; slots are stored back to back.
  function automatic logic [ADDR_W-1:0] base_addr(input logic [ID_W-1:0] id);
    return ADDR_W'(id) * ADDR_W'(SPR_SIZE);
  endfunction

endpackage

// File: rtl/sprite_fetch_scheduler_if.sv
// Position-update handshake between game logic and the sprite fetch scheduler.
interface sprite_fetch_scheduler_if;
  import sprite_sched_pkg::*;

  logic            upd_valid;
  logic            upd_ready;
  logic [ID_W-1:0] upd_id;
  logic [9:0]      upd_x;
  logic [9:0]      upd_y;
  logic            upd_en;

  modport master (output upd_valid, upd_id, upd_x, upd_y, upd_en, input upd_ready);
  modport slave  (input upd_valid, upd_id, upd_x, upd_y, upd_en, output upd_ready);

endinterface

// File: rtl/sprite_hit_test.sv
// Per-slot coverage test: does this sprite cover the current pixel, and at which local offset.
module sprite_hit_test
  import sprite_sched_pkg::*;
(
  input  slot_t            slot,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  input  logic             blank,
  output logic             hit,
  output logic [OFF_W-1:0] dx,
  output logic [OFF_W-1:0] dy
);

  logic [10:0] px, py, x_lo, y_lo, x_hi, y_hi;

  // Bounds are widened to 11 bits so a sprite near column 1023 cannot wrap onto column 0.
  always_comb begin
    px   = {1'b0, DrawX};
    py   = {1'b0, DrawY};
    x_lo = {1'b0, slot.x};
    y_lo = {1'b0, slot.y};
    x_hi = x_lo + 11'(SPR_W);
    y_hi = y_lo + 11'(SPR_H);
    hit  = slot.en & blank & (px >= x_lo) & (px < x_hi) & (py >= y_lo) & (py < y_hi);
    dx   = OFF_W'(DrawX - slot.x);
    dy   = OFF_W'(DrawY - slot.y);
  end

endmodule

// File: rtl/sprite_fetch_scheduler.sv
// Shares one sprite ROM port among several sprites: shadow/active position registers,
// per-pixel priority hit test, and a 2-cycle fetch pipeline to the palette mux.
module sprite_fetch_scheduler
  import sprite_sched_pkg::*;
(
  input  logic                     vga_clk,
  input  logic                     reset_n,
  input  logic [9:0]               DrawX,
  input  logic [9:0]               DrawY,
  input  logic                     blank,
  input  logic                     frame_start,
  sprite_fetch_scheduler_if.slave  upd,
  output logic [ADDR_W-1:0]        rom_address,
  input  logic [IDX_W-1:0]         rom_q,
  output logic                     pix_hit,
  output logic [ID_W-1:0]          pix_id,
  output logic [IDX_W-1:0]         pix_index,
  output logic [15:0]              frame_cnt
);

  state_e state_q, state_d;
  logic   commit;
  logic   ready_q;
  logic   accept;

  slot_t shadow_q [NUM_SPRITES];
  slot_t active_q [NUM_SPRITES];

  logic [NUM_SPRITES-1:0] hit;
  logic [OFF_W-1:0]       dx [NUM_SPRITES];
  logic [OFF_W-1:0]       dy [NUM_SPRITES];

  logic              any_hit;
  logic [ID_W-1:0]   win_id;
  logic [OFF_W-1:0]  win_dx, win_dy;
  logic [ADDR_W-1:0] fetch_addr;
  logic              hit_d;
  logic [ID_W-1:0]   id_d;

  assign accept        = upd.upd_valid & ready_q;
  assign upd.upd_ready = ready_q;

  // Frame FSM next state; the commit fires on entry to StCommit, before same-cycle updates land.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    unique case (state_q)
      StRun: begin
        if (frame_start) begin
          state_d = StCommit;
          commit  = 1'b1;
        end
      end
      StCommit: state_d = StRun;
      default:  state_d = StRun;
    endcase
  end

  // FSM state, registered ready and committed-frame counter.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StRun;
      ready_q   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == StRun);
      if (commit) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Shadow writes from the update port; active copy taken atomically at commit.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      // Ids outside the slot range match no slot, so the handshake completes with no write.
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (accept && (upd.upd_id == ID_W'(i))) begin
          shadow_q[i] <= '{en: upd.upd_en, x: upd.upd_x, y: upd.upd_y};
        end
        if (commit) active_q[i] <= shadow_q[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
    sprite_hit_test u_hit (
      .slot  (active_q[g]),
      .DrawX (DrawX),
      .DrawY (DrawY),
      .blank (blank),
      .hit   (hit[g]),
      .dx    (dx[g]),
      .dy    (dy[g])
    );
  end

  // Priority encoder: lowest-index hit wins, then form its ROM address.
  always_comb begin
    any_hit = |hit;
    win_id  = '0;
    win_dx  = '0;
    win_dy  = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win_id = ID_W'(i);
        win_dx = dx[i];
        win_dy = dy[i];
      end
    end
    fetch_addr = base_addr(win_id) + ADDR_W'(win_dy) * ADDR_W'(SPR_W) + ADDR_W'(win_dx);
  end

  // Stage 1: ROM address and hit/id tags; address holds when nothing is hit.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_address <= '0;
      hit_d       <= 1'b0;
      id_d        <= '0;
    end else begin
      if (any_hit) rom_address <= fetch_addr;
      hit_d <= any_hit;
      id_d  <= win_id;
    end
  end

  // Stage 2: combine ROM data with the tags; transparent winner hides everything beneath.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_hit   <= 1'b0;
      pix_id    <= '0;
      pix_index <= '0;
    end else begin
      pix_hit   <= hit_d & (rom_q != TRANSP_IDX);
      pix_id    <= id_d;
      pix_index <= hit_d ? rom_q : '0;
    end
  end

endmodule

// File: doc/sprite_fetch_scheduler.md
Name: sprite_fetch_scheduler

Overview:
- Shares one sprite-sheet ROM read port among NUM_SPRITES on-screen objects (player, balls, harpoon).
- Per pixel: decides which sprite, if any, covers (DrawX, DrawY); generates that sprite's ROM address; returns its palette index to the palette/colour mux.
- Game logic writes sprite positions through a valid/ready port into shadow registers. Shadow values commit atomically at frame start, so no sprite tears.

Parameters:
- NUM_SPRITES, 4: number of sprite slots; slot 0 has highest priority.
- SPR_W, 43: sprite width in pixels; identical for all slots.
- SPR_H, 50: sprite height in pixels.
- ADDR_W, 14: ROM address width; must hold NUM_SPRITES*SPR_W*SPR_H.
- IDX_W, 9: palette index width (rom_q).
- TRANSP_IDX, 0: palette index treated as transparent.

Ports:
- vga_clk  in  1  pixel clock; all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- blank  in  1  1 = active display region.
- frame_start  in  1  one-cycle pulse at first vblank line.
- upd_valid  in  1  position update request.
- upd_ready  out  1  update accepted when upd_valid & upd_ready.
- upd_id  in  $clog2(NUM_SPRITES)  slot to update.
- upd_x  in  10  new top-left X.
- upd_y  in  10  new top-left Y.
- upd_en  in  1  slot visible.
- rom_address  out  ADDR_W  registered ROM address; ROM is clocked on ~vga_clk.
- rom_q  in  IDX_W  ROM data, valid at the posedge after rom_address changes.
- pix_hit  out  1  opaque sprite pixel present.
- pix_id  out  $clog2(NUM_SPRITES)  winning slot.
- pix_index  out  IDX_W  palette index.
- frame_cnt  out  16  committed-frame counter.

Behaviour:
- Reset (reset_n=0, async): every shadow and active slot disabled, X=Y=0. rom_address=0, pix_hit=0, pix_id=0, pix_index=0, frame_cnt=0, upd_ready=0. FSM enters RUN. upd_ready=1 from the first posedge after reset release.
- FSM states:
  - RUN: upd_ready=1. frame_start -> COMMIT.
  - COMMIT (exactly 1 cycle): active <= shadow for all slots; frame_cnt += 1 (wraps 0xFFFF->0); upd_ready=0; -> RUN.
- Update handshake: on upd_valid & upd_ready, shadow[upd_id] <= {upd_en, upd_x, upd_y}.
  - upd_id >= NUM_SPRITES: handshake completes but nothing is written.
  - Update in the same cycle as frame_start: accepted (RUN state), lands in shadow, not in this commit. Latest shadow value wins.
  - Multiple updates to one slot within a frame: last one wins.
- Stage 0, combinational on the sampled DrawX/DrawY:
  - hit_i = en_i & blank & x_i <= DrawX < x_i+SPR_W & y_i <= DrawY < y_i+SPR_H.
  - Bounds are compared at 11 bits, so x_i near 1023 never wraps. A sprite partially off-screen draws only its on-screen part.
  - Winner is the lowest-index hit.
- Stage 1 (posedge k+1):
  - rom_address <= winner*SPR_W*SPR_H + (DrawY-y_w)*SPR_W + (DrawX-x_w). No divider; constant multiplies only.
  - hit_d <= any hit; id_d <= winner.
  - No hit: rom_address holds its previous value.
- Stage 2 (posedge k+2):
  - pix_hit <= hit_d & (rom_q != TRANSP_IDX).
  - pix_id <= id_d.
  - pix_index <= hit_d ? rom_q : 0.
  - Total latency is 2 vga_clk cycles from DrawX/DrawY to outputs. The downstream mux delays the background by 2 cycles to match.
- Transparency: only the winning slot is fetched. A transparent pixel of the winner yields pix_hit=0, and lower-priority sprites are not shown beneath it. This is an accepted limitation.
- Reset mid-frame: pipeline flushes to 0; sprites stay invisible until the first COMMIT after updates.

Decomposition:
- Package sprite_sched_pkg:
  - slot_t struct {en, x[9:0], y[9:0]}.
  - SPR_W, SPR_H, SPR_SIZE=SPR_W*SPR_H.
  - TRANSP_IDX.
  - Function base_addr(id).
- Sub-module sprite_hit_test: one instance per slot via generate. Inputs: slot_t, DrawX, DrawY, blank. Outputs: hit and local offset {dx, dy}.
- Priority encoder and FSM stay in the top level.

Test Plan:
- Reset, then no updates: sweep a full frame -> pix_hit=0 everywhere; frame_cnt increments once per frame_start.
- Write slot 1 to (100,200) en=1, pulse frame_start, drive (100,200):
  - rom_address=2150 one cycle later.
  - pix_id=1 two cycles later.
  - pix_index equals ROM model value at 2150.
  - (143,200) and (100,250) -> pix_hit=0.
- Slots 0 and 2 both at (300,100), drive (310,110):
  - pix_id=0; rom_address = 10*43 + 10 = 440.
  - If ROM@440 == TRANSP_IDX -> pix_hit=0.
- upd_valid in the same cycle as frame_start, slot 3 at (50,50):
  - No hit at (50,50) this frame.
  - Hit after the next frame_start.
- Slot 0 at (620,470), drive (639,479) -> hit, rom_address = 9*43 + 19 = 406. Slot at x=1000 -> never hits, no wrap.
- Assert reset_n mid-line with sprites active -> outputs 0 immediately (async); after release, no hits until the next commit.
